si5340_reg_sequencer: RTL

Sequences single Si5340 register writes onto the shared I2C byte-command controller. It accepts a 16-bit register address (page in bits [15:8], register in bits [7:0]) and an 8-bit data byte over a valid/ready request port. It emits the byte-level START/WRITE/READ/STOP commands, including a page-select write to register 0x01 only when the page differs from the cached page. It sits between the config-memory walker and the I2C byte controller and returns a one-cycle status response per request.

---
 rtl/si5340_reg_sequencer.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/si5340_reg_sequencer.sv
// ---------------------------------------------------------------------------
// si5340_reg_sequencer
//
// Turns one Si5340 register write request into the byte-level command
// sequence for the shared I2C byte controller. A page-select write to
// register 0x01 is inserted only when the requested page differs from the
// cached page, or when no page is cached.
//
// Optional feature macro: SI5340_SEQ_READBACK_EN
//   When defined, every write is followed by a readback of the same register.
//   The readback byte is returned on rsp_rdata_o, and a mismatch is reported.
//   When undefined, the readback states do not exist and rsp_rdata_o is 0.
//
// Ports
//   clk_i, arstn_i        clock, asynchronous active-low reset
//   req_valid_i/ready_o   request handshake
//   req_addr_i            [15:8] page, [7:0] register
//   req_data_i            register data
//   rsp_valid_o           one-cycle completion pulse
//   rsp_err_o             00 ok, 01 NACK, 10 readback mismatch, 11 timeout
//   rsp_rdata_o           readback byte
//   cmd_start_o .. cmd_ack_in_o, cmd_din_o   byte-controller command
//   cmd_dout_i, cmd_done_i, cmd_rxack_i      byte-controller status
//   dbg_state_o           current FSM state, for observation only
//
// Handshake: a request transfers on a rising clk_i edge where req_valid_i
// and req_ready_o are both high. req_ready_o is high only while idle. A byte
// command is held on cmd_* until a cycle with cmd_done_i high. The command
// is cleared in the following cycle. The next command is issued one cycle
// after that.
// ---------------------------------------------------------------------------
module si5340_reg_sequencer #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h74,
  parameter int         TIMEOUT_CYC = 65535
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_data_i,
  output logic        rsp_valid_o,
  output logic [1:0]  rsp_err_o,
  output logic [7:0]  rsp_rdata_o,
  output logic        cmd_start_o,
  output logic        cmd_stop_o,
  output logic        cmd_write_o,
  output logic        cmd_read_o,
  output logic        cmd_ack_in_o,
  output logic [7:0]  cmd_din_o,
  input  logic [7:0]  cmd_dout_i,
  input  logic        cmd_done_i,
  input  logic        cmd_rxack_i,
  output logic [3:0]  dbg_state_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0] SLA_W = {SLAVE_ADDR, 1'b0};
`ifdef SI5340_SEQ_READBACK_EN
  localparam logic [7:0] SLA_R = {SLAVE_ADDR, 1'b1};
`endif

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
`ifdef SI5340_SEQ_READBACK_EN
  localparam logic [1:0] ERR_RB   = 2'b10;
`endif
  localparam logic [1:0] ERR_TO   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PG_ADDR,
    S_PG_REG,
    S_PG_DATA,
    S_WR_ADDR,
    S_WR_REG,
    S_WR_DATA,
`ifdef SI5340_SEQ_READBACK_EN
    S_RB_ADDR,
    S_RB_REG,
    S_RB_RADDR,
    S_RB_READ,
`endif
    S_ABORT,
    S_RESP
  } state_t;

  // Command vector layout: {start, stop, write, read, ack_in, din[7:0]}
  function automatic logic [12:0] step_cmd(input state_t s,
                                           input logic [7:0] pg,
                                           input logic [7:0] rg,
                                           input logic [7:0] dt);
    logic [12:0] c;
    c = 13'd0;
    case (s)
      S_PG_ADDR:  c = {5'b10100, SLA_W};
      S_PG_REG:   c = {5'b00100, 8'h01};
      S_PG_DATA:  c = {5'b01100, pg};
      S_WR_ADDR:  c = {5'b10100, SLA_W};
      S_WR_REG:   c = {5'b00100, rg};
      S_WR_DATA:  c = {5'b01100, dt};
`ifdef SI5340_SEQ_READBACK_EN
      S_RB_ADDR:  c = {5'b10100, SLA_W};
      S_RB_REG:   c = {5'b00100, rg};
      S_RB_RADDR: c = {5'b10100, SLA_R};
      S_RB_READ:  c = {5'b01011, 8'h00};  // last byte of a read: master NACKs
`endif
      S_ABORT:    c = {5'b01000, 8'h00};
      default:    c = 13'd0;
    endcase
    return c;
  endfunction

  function automatic state_t next_st(input state_t s);
    state_t n;
    n = S_RESP;
    case (s)
      S_PG_ADDR:  n = S_PG_REG;
      S_PG_REG:   n = S_PG_DATA;
      S_PG_DATA:  n = S_WR_ADDR;
      S_WR_ADDR:  n = S_WR_REG;
      S_WR_REG:   n = S_WR_DATA;
`ifdef SI5340_SEQ_READBACK_EN
      S_WR_DATA:  n = S_RB_ADDR;
      S_RB_ADDR:  n = S_RB_REG;
      S_RB_REG:   n = S_RB_RADDR;
      S_RB_RADDR: n = S_RB_READ;
`endif
      default:    n = S_RESP;
    endcase
    return n;
  endfunction

  state_t           state_q;
  logic             busy_q;       // a command is on the bus (or RESP is pulsing)
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      addr_q;
  logic [7:0]       data_q;
  logic [7:0]       page_q;
  logic             page_valid_q;
  logic [1:0]       err_q;
  logic             rsp_valid_q;
  logic             req_ready_q;
  logic [12:0]      cmd_q;
`ifdef SI5340_SEQ_READBACK_EN
  logic [7:0]       rdata_q;
`endif

  state_t first_st;
  always_comb begin
    first_st = S_WR_ADDR;
    if (!page_valid_q || (req_addr_i[15:8] != page_q)) first_st = S_PG_ADDR;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= 16'h0000;
      data_q       <= 8'h00;
      page_q       <= 8'h00;
      page_valid_q <= 1'b0;
      err_q        <= ERR_OK;
      rsp_valid_q  <= 1'b0;
      req_ready_q  <= 1'b0;
      cmd_q        <= 13'd0;
`ifdef SI5340_SEQ_READBACK_EN
      rdata_q      <= 8'h00;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            // First command goes out in the cycle right after acceptance.
            addr_q      <= req_addr_i;
            data_q      <= req_data_i;
            err_q       <= ERR_OK;
`ifdef SI5340_SEQ_READBACK_EN
            rdata_q     <= 8'h00;
`endif
            req_ready_q <= 1'b0;
            state_q     <= first_st;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            cmd_q       <= step_cmd(first_st, req_addr_i[15:8],
                                    req_addr_i[7:0], req_data_i);
          end
        end

        S_RESP: begin
          if (!busy_q) begin
            rsp_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end else begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end

        default: begin
          if (!busy_q) begin
            // Issue this state's byte command after the one-cycle gap.
            busy_q <= 1'b1;
            cnt_q  <= '0;
            cmd_q  <= step_cmd(state_q, addr_q[15:8], addr_q[7:0], data_q);
          end else if (cmd_done_i) begin
            // Done takes priority over a coincident timeout terminal count.
            cmd_q  <= 13'd0;
            busy_q <= 1'b0;
            if (cmd_q[10] && cmd_rxack_i) begin
              err_q        <= ERR_NACK;
              page_valid_q <= 1'b0;
              // A step that already sent STOP has released the bus.
              state_q      <= cmd_q[11] ? S_RESP : S_ABORT;
            end else begin
              if (state_q == S_PG_DATA) begin
                page_q       <= addr_q[15:8];
                page_valid_q <= 1'b1;
              end
`ifdef SI5340_SEQ_READBACK_EN
              if (state_q == S_RB_READ) begin
                rdata_q <= cmd_dout_i;
                if (cmd_dout_i != data_q) begin
                  err_q        <= ERR_RB;
                  page_valid_q <= 1'b0;
                end
              end
`endif
              state_q <= next_st(state_q);
            end
          end else if (cnt_q == CNT_LAST) begin
            // Controller presumed hung: drop the command, no STOP, respond now.
            cmd_q        <= 13'd0;
            err_q        <= ERR_TO;
            page_valid_q <= 1'b0;
            state_q      <= S_RESP;
            busy_q       <= 1'b1;
            rsp_valid_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_err_o    = err_q;
  assign cmd_start_o  = cmd_q[12];
  assign cmd_stop_o   = cmd_q[11];
  assign cmd_write_o  = cmd_q[10];
  assign cmd_read_o   = cmd_q[9];
  assign cmd_ack_in_o = cmd_q[8];
  assign cmd_din_o    = cmd_q[7:0];
  assign dbg_state_o  = state_q;

`ifdef SI5340_SEQ_READBACK_EN
  assign rsp_rdata_o = rdata_q;
`else
  assign rsp_rdata_o = 8'h00;
  logic unused_dout;
  assign unused_dout = ^cmd_dout_i;
`endif

endmodule
